// File: rtl/sync_word_packer_pkg.sv
// Shared definitions for the synchronizer-side word packer: default bus width,
// output FSM encoding and a constant-evaluable clog2 helper.
package sync_word_packer_pkg;

    localparam int DEFAULT_BUS_WIDTH = 8;
    localparam int DEFAULT_NUM_BYTES = 4;
    localparam int WORD_WIDTH        = DEFAULT_BUS_WIDTH * DEFAULT_NUM_BYTES;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, cleared by rst.
module sync_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sync_word_packer.sv
// Packs NUM_BYTES synchronized beats LSB-first into one word and offers it on a
// single-entry valid/ready output; words that cannot be stored are counted as drops.
module sync_word_packer
    import sync_word_packer_pkg::*;
#(
    parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
    parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
    parameter int CNT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [BUS_WIDTH-1:0]             sync_bus,
    input  logic                             enable_pulse,
    input  logic                             clear,
    output logic [BUS_WIDTH*NUM_BYTES-1:0]   out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [clog2(NUM_BYTES):0]        fill_level,
    output logic                             overflow,
    output logic [CNT_WIDTH-1:0]             drop_cnt
);

    localparam int FW = clog2(NUM_BYTES) + 1;
    localparam int WW = BUS_WIDTH * NUM_BYTES;
    localparam logic [FW-1:0] LAST_LANE = FW'(NUM_BYTES - 1);

    logic [FW-1:0]                          fill_q, fill_d;
    // The top lane is never stored: it is taken straight from sync_bus on completion.
    logic [NUM_BYTES-2:0][BUS_WIDTH-1:0]    lanes_q, lanes_d;
    logic [NUM_BYTES-2:0]                   lane_we;
    logic [WW-1:0]                          out_data_q, out_data_d;
    logic                                   overflow_q, overflow_d;
    out_state_e                             out_state_q, out_state_d;

    logic          word_done;
    logic          load_word;
    logic          drop_word;
    logic [WW-1:0] word_full;

    // ---------------- lane counter FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_comb begin
        fill_d    = fill_q;
        word_done = 1'b0;
        if (clear) begin
            // Start-of-frame: a beat arriving with clear becomes lane 0.
            fill_d = enable_pulse ? FW'(1) : '0;
        end else if (enable_pulse) begin
            if (fill_q == LAST_LANE) begin
                fill_d    = '0;
                word_done = 1'b1;
            end else begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // ---------------- partial-word lanes ----------------
    for (genvar gi = 0; gi < NUM_BYTES - 1; gi++) begin : g_lane
        assign lane_we[gi] = enable_pulse &&
                             (clear ? (gi == 0) : (fill_q == FW'(gi)));
        assign lanes_d[gi] = lane_we[gi] ? sync_bus : lanes_q[gi];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign word_full = {sync_bus, lanes_q};

    // ---------------- output FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q <= OUT_EMPTY;
            out_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            overflow_q  <= overflow_d;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        if (out_state_q == OUT_EMPTY) begin
            if (word_done) begin
                out_state_d = OUT_FULL;
            end
        end else begin
            if (!word_done && out_ready) begin
                out_state_d = OUT_EMPTY;
            end
        end
    end

    always_comb begin
        load_word  = word_done && ((out_state_q == OUT_EMPTY) || out_ready);
        drop_word  = word_done && (out_state_q == OUT_FULL) && !out_ready;
        out_data_d = load_word ? word_full : out_data_q;
        overflow_d = overflow_q | drop_word;
    end

    sync_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop_word),
        .count (drop_cnt)
    );

    assign out_data   = out_data_q;
    assign out_valid  = (out_state_q == OUT_FULL);
    assign fill_level = fill_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_sync_word_packer.sv
// Directed bench for sync_word_packer (BUS_WIDTH=8, NUM_BYTES=4, CNT_WIDTH=8).
module tb_sync_word_packer;

    logic        clk;
    logic        rst;
    logic [7:0]  sync_bus;
    logic        enable_pulse;
    logic        clear;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  fill_level;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int total_checks;
    int passed_checks;
    int failed_checks;

    sync_word_packer #(
        .BUS_WIDTH (8),
        .NUM_BYTES (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sync_bus     (sync_bus),
        .enable_pulse (enable_pulse),
        .clear        (clear),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill_level   (fill_level),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge with the given inputs; returns 1 time unit after the edge.
    task automatic step(input logic en, input logic [7:0] d, input logic rdy, input logic clr);
        enable_pulse = en;
        sync_bus     = d;
        out_ready    = rdy;
        clear        = clr;
        @(posedge clk);
        #1;
        enable_pulse = 1'b0;
        clear        = 1'b0;
        $display("t=%0t en=%0b bus=%02h rdy=%0b clr=%0b -> fill=%0d valid=%0b data=%08h ovf=%0b drop=%0d",
                 $time, en, d, rdy, clr, fill_level, out_valid, out_data, overflow, drop_cnt);
    endtask

    task automatic push_word(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input logic rdy);
        step(1'b1, b0, 1'b0, 1'b0);
        step(1'b1, b1, 1'b0, 1'b0);
        step(1'b1, b2, 1'b0, 1'b0);
        step(1'b1, b3, rdy, 1'b0);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        rst           = 1'b0;
        sync_bus      = '0;
        enable_pulse  = 1'b0;
        clear         = 1'b0;
        out_ready     = 1'b0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check("reset_fill",     64'(fill_level), 64'd0);
        check("reset_valid",    64'(out_valid),  64'd0);
        check("reset_data",     64'(out_data),   64'd0);
        check("reset_overflow", 64'(overflow),   64'd0);
        check("reset_drop",     64'(drop_cnt),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic packing with consumer ready
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        check("t1_fill1", 64'(fill_level), 64'd1);
        check("t1_valid_b1", 64'(out_valid), 64'd0);
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("t1_fill2", 64'(fill_level), 64'd2);
        step(1'b1, 8'hFF, 1'b1, 1'b0);
        check("t1_fill3", 64'(fill_level), 64'd3);
        check("t1_valid_b3", 64'(out_valid), 64'd0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        check("t1_fill0", 64'(fill_level), 64'd0);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'h3CFF5AA5);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t1_valid_drop", 64'(out_valid), 64'd0);
        check("t1_data_hold", 64'(out_data), 64'h3CFF5AA5);

        // Overrun with consumer stalled
        push_word(8'h01, 8'h02, 8'h03, 8'h04, 1'b0);
        check("t2_valid", 64'(out_valid), 64'd1);
        check("t2_data1", 64'(out_data), 64'h04030201);
        check("t2_ovf_before", 64'(overflow), 64'd0);
        push_word(8'h05, 8'h06, 8'h07, 8'h08, 1'b0);
        check("t2_overflow", 64'(overflow), 64'd1);
        check("t2_drop", 64'(drop_cnt), 64'd1);
        check("t2_data_kept", 64'(out_data), 64'h04030201);
        check("t2_valid_kept", 64'(out_valid), 64'd1);

        // Consume and reload on the same edge: no bubble
        push_word(8'h11, 8'h12, 8'h13, 8'h14, 1'b1);
        check("t3_valid", 64'(out_valid), 64'd1);
        check("t3_data", 64'(out_data), 64'h14131211);
        check("t3_drop", 64'(drop_cnt), 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_consumed", 64'(out_valid), 64'd0);

        // Clear with a beat restarts the frame at lane 0
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        check("t4_fill_pre", 64'(fill_level), 64'd2);
        step(1'b1, 8'hCC, 1'b0, 1'b1);
        check("t4_fill_clear", 64'(fill_level), 64'd1);
        check("t4_valid_clear", 64'(out_valid), 64'd0);
        step(1'b1, 8'hDD, 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        check("t4_valid", 64'(out_valid), 64'd1);
        check("t4_data", 64'(out_data), 64'hFFEEDDCC);
        check("t4_drop", 64'(drop_cnt), 64'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_consumed", 64'(out_valid), 64'd0);

        // Saturating drop counter: 300 drops on top of the existing 1
        push_word(8'h21, 8'h22, 8'h23, 8'h24, 1'b0);
        check("t5_loaded", 64'(out_data), 64'h24232221);
        for (int w = 0; w < 253; w++) begin
            push_word(8'h99, 8'h98, 8'h97, 8'h96, 1'b0);
        end
        check("t5_drop_fe", 64'(drop_cnt), 64'hFE);
        push_word(8'h99, 8'h98, 8'h97, 8'h96, 1'b0);
        check("t5_drop_ff", 64'(drop_cnt), 64'hFF);
        for (int w = 0; w < 46; w++) begin
            push_word(8'h99, 8'h98, 8'h97, 8'h96, 1'b0);
        end
        check("t5_drop_sat", 64'(drop_cnt), 64'hFF);
        check("t5_overflow", 64'(overflow), 64'd1);
        check("t5_data_kept", 64'(out_data), 64'h24232221);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_ovf_after_clear", 64'(overflow), 64'd1);
        check("t5_drop_after_clear", 64'(drop_cnt), 64'hFF);

        // Asynchronous reset mid-word with a word pending
        step(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 8'h88, 1'b0, 1'b0);
        check("t6_fill_pre", 64'(fill_level), 64'd2);
        check("t6_valid_pre", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_fill", 64'(fill_level), 64'd0);
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_data", 64'(out_data), 64'd0);
        check("t6_rst_overflow", 64'(overflow), 64'd0);
        check("t6_rst_drop", 64'(drop_cnt), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 8'h41, 1'b0, 1'b0);
        check("t6_fill1", 64'(fill_level), 64'd1);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b1, 8'h43, 1'b0, 1'b0);
        check("t6_valid_b3", 64'(out_valid), 64'd0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_data", 64'(out_data), 64'h44434241);
        check("t6_drop", 64'(drop_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
